// File: rtl/rej_bounded_sampler.sv
// rej_bounded_sampler: parallel eta-bounded rejection sampler with an in-order compaction buffer
module rej_bounded_sampler #(
    parameter int NUM_NIBBLES   = 8,
    parameter int NUM_COEFF_OUT = 4,
    parameter int BUF_DEPTH     = 16,
    parameter int NUM_COEFF     = 256,
    parameter int REJ_Q         = 8380417,
    parameter int COEFF_W       = 23
) (
    input  logic                               clk,
    input  logic                               rst_b,
    input  logic                               zeroize,
    input  logic                               start,
    input  logic                               eta_mode,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [4*NUM_NIBBLES-1:0]           in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_COEFF_OUT*COEFF_W-1:0]   out_data,
    output logic                               done
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int KW = $clog2(NUM_COEFF + 1);
    localparam int BW = BUF_DEPTH * COEFF_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic                 eta_q, eta_d;
    logic [CW-1:0]        count_q, count_d;
    logic [KW-1:0]        ctr_q, ctr_d;
    logic [BW-1:0]        buf_q, buf_d;
    logic [NUM_NIBBLES-1:0] acc;
    logic [COEFF_W-1:0]   coeff [NUM_NIBBLES];
    logic                 in_fire, out_fire, last;

    assign in_ready  = state_q == RUN && count_q <= CW'(BUF_DEPTH - NUM_NIBBLES);
    assign out_valid = state_q == RUN && count_q >= CW'(NUM_COEFF_OUT);
    assign out_data  = buf_q[NUM_COEFF_OUT*COEFF_W-1:0];
    assign done      = state_q == DONE;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last      = out_fire && ctr_q == KW'(NUM_COEFF - NUM_COEFF_OUT);

    // Classify every nibble: accept flag and its small signed value folded into [0, REJ_Q)
    always_comb begin : classify
        logic [3:0] t, f, r, s, ns;
        acc = '0;
        for (int j = 0; j < NUM_NIBBLES; j++) begin
            t        = in_data[4*j +: 4];
            f        = {2'b00, t[1:0]} - {2'b00, t[3:2]};
            r        = f[3] ? f + 4'd5 : f;
            s        = eta_q ? 4'd4 - t : 4'd2 - r;
            ns       = 4'd0 - s;
            acc[j]   = eta_q ? t < 4'd9 : t != 4'd15;
            coeff[j] = s[3] ? COEFF_W'(REJ_Q) - COEFF_W'(ns) : COEFF_W'(s);
        end
    end

    // Next state and eta latch
    always_comb begin
        state_d = state_q;
        eta_d   = eta_q;
        if (state_q == IDLE && start) begin
            state_d = RUN;
            eta_d   = eta_mode;
        end
        if (state_q == RUN && last)
            state_d = DONE;
        if (state_q == DONE)
            state_d = IDLE;
    end

    // Buffer shift-out plus in-order append of accepted coefficients behind survivors
    always_comb begin : datapath
        logic [BW-1:0] sh;
        int base, pos;
        sh    = out_fire ? buf_q >> (NUM_COEFF_OUT * COEFF_W) : buf_q;
        base  = int'(count_q) - (out_fire ? NUM_COEFF_OUT : 0);
        buf_d = '0;
        for (int i = 0; i < BUF_DEPTH; i++)
            if (i < base)
                buf_d[i*COEFF_W +: COEFF_W] = sh[i*COEFF_W +: COEFF_W];
        pos = base;
        for (int j = 0; j < NUM_NIBBLES; j++)
            if (in_fire && acc[j]) begin
                for (int i = 0; i < BUF_DEPTH; i++)
                    if (i == pos)
                        buf_d[i*COEFF_W +: COEFF_W] = coeff[j];
                pos = pos + 1;
            end
        count_d = CW'(pos);
        ctr_d   = out_fire ? ctr_q + KW'(NUM_COEFF_OUT) : ctr_q;
        if (state_d != RUN) begin
            buf_d   = '0;
            count_d = '0;
            ctr_d   = '0;
        end
    end

    // State registers; zeroize clears exactly like reset
    always_ff @(posedge clk) begin
        if (!rst_b || zeroize) begin
            state_q <= IDLE;
            eta_q   <= 1'b0;
            count_q <= '0;
            ctr_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            eta_q   <= eta_d;
            count_q <= count_d;
            ctr_q   <= ctr_d;
            buf_q   <= buf_d;
        end
    end
endmodule

// File: tb/tb_rej_bounded_sampler.sv
// tb_rej_bounded_sampler: directed and stream checks of the bounded rejection sampler
module tb_rej_bounded_sampler;
    localparam int Q = 8380417;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        zeroize = 1'b0;
    logic        start = 1'b0;
    logic        eta_mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, done;
    logic [91:0] out_data;

    int total = 0;
    int bad = 0;

    rej_bounded_sampler dut (
        .clk(clk), .rst_b(rst_b), .zeroize(zeroize), .start(start), .eta_mode(eta_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return 32'(out_data[i*23 +: 23]);
    endfunction

    function automatic int exp_coef(input int eta, input int t);
        if (eta == 0) return (t >= 15) ? -1 : (2 - t % 5 + Q) % Q;
        return (t >= 9) ? -1 : (4 - t + Q) % Q;
    endfunction

    task automatic beat(input string tag, input int a, input int b, input int c, input int d);
        chk({tag, "_l0"}, lane(0), a);
        chk({tag, "_l1"}, lane(1), b);
        chk({tag, "_l2"}, lane(2), c);
        chk({tag, "_l3"}, lane(3), d);
    endtask

    task automatic go(input logic eta);
        start = 1'b1;
        eta_mode = eta;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic word(input logic [31:0] d);
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic clear();
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
    endtask

    initial begin
        int words, beats, dones, cyc, v;
        int q[$];
        logic fin;
        logic [31:0] d;
        // reset with input pressure
        in_valid = 1'b1;
        in_data = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", {31'b0, |out_data}, 0);
        rst_b = 1'b1;
        in_valid = 1'b0;
        // eta=2 all accepted
        go(0);
        chk("run_in_ready", in_ready, 1);
        word(32'h0000_0E53);
        chk("e2_out_valid", out_valid, 1);
        beat("e2_beat0", Q - 1, 2, Q - 2, 2);
        out_ready = 1'b1;
        @(negedge clk);
        beat("e2_beat1", 2, 2, 2, 2);
        chk("e2_out_valid2", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("e2_drained", out_valid, 0);
        clear();
        // nothing accepted
        go(0);
        word(32'hFFFF_FFFF);
        chk("rej_in_ready", in_ready, 1);
        chk("rej_out_valid", out_valid, 0);
        clear();
        // eta=4 single accept, then zeroize at count 5
        go(1);
        word(32'hFFFF_FF95);
        chk("e4_one_valid", out_valid, 0);
        chk("e4_one_lane0", lane(0), Q - 1);
        word(32'hFFFF_4444);
        chk("cnt5_valid", out_valid, 1);
        clear();
        chk("zero_in_ready", in_ready, 0);
        chk("zero_out_valid", out_valid, 0);
        chk("zero_out_data", {31'b0, |out_data}, 0);
        go(1);
        word(32'hFFFF_F000);
        chk("post_zero_valid", out_valid, 0);
        chk("post_zero_lane0", lane(0), 4);
        clear();
        // backpressure
        go(1);
        in_valid = 1'b1;
        in_data = 32'h3333_3333;
        repeat (4) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        beat("bp_hold0", 1, 1, 1, 1);
        repeat (3) @(negedge clk);
        beat("bp_hold1", 1, 1, 1, 1);
        words = 2;
        beats = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            in_valid = c < 20;
            if (in_valid && in_ready) words++;
            if (out_valid && out_ready) beats++;
            @(negedge clk);
        end
        chk("bp_no_loss", beats * 4, words * 8);
        chk("bp_drained", out_valid, 0);
        out_ready = 1'b0;
        clear();
        // start during RUN ignored
        go(0);
        start = 1'b1;
        eta_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        word(32'hFFFF_FFF9);
        chk("start_ign_lane0", lane(0), Q - 2);
        clear();
        go(1);
        word(32'h0000_0008);
        beat("e4_eight", Q - 4, 4, 4, 4);
        clear();
        // full polynomial against a golden queue
        go(0);
        beats = 0;
        dones = 0;
        cyc = 0;
        fin = 1'b0;
        while (cyc < 4000 && !fin) begin
            for (int j = 0; j < 8; j++)
                d[4*j +: 4] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            in_data = d;
            in_valid = $urandom_range(0, 4) != 0;
            out_ready = $urandom_range(0, 1);
            if (in_valid && in_ready)
                for (int j = 0; j < 8; j++) begin
                    v = exp_coef(0, int'(d[4*j +: 4]));
                    if (v >= 0) q.push_back(v);
                end
            if (out_valid && out_ready) begin
                for (int i = 0; i < 4; i++)
                    chk("full_coef", lane(i), q.size() > 0 ? q.pop_front() : -1);
                beats++;
            end
            @(negedge clk);
            cyc++;
            if (beats == 64) begin
                fin = 1'b1;
                chk("full_done", done, 1);
                chk("full_in_ready_end", in_ready, 0);
                chk("full_out_valid_end", out_valid, 0);
            end else if (done) dones++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("full_beats", beats, 64);
        chk("full_early_done", dones, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_in_ready", in_ready, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rej_bounded_sampler.md
Name: rej_bounded_sampler

Overview:
- Sequential, multi-lane rejection sampler for ML-DSA secret-vector coefficients with bounded range.
- Each cycle it takes one word of NUM_NIBBLES 4-bit candidates, checks them all in parallel for the selected eta mode, and maps the accepted ones to coefficients mod REJ_Q.
- Accepted coefficients are compacted in order into a buffer and drained in fixed beats of NUM_COEFF_OUT coefficients.
- It sits between the SHAKE256 output stream and the polynomial memory writer, and stops after exactly NUM_COEFF coefficients.

Parameters:
- NUM_NIBBLES, 8, candidates per input word; in_data width is 4*NUM_NIBBLES.
- NUM_COEFF_OUT, 4, coefficients per output beat.
- BUF_DEPTH, 16, compaction buffer entries; must be >= NUM_NIBBLES+NUM_COEFF_OUT-1.
- NUM_COEFF, 256, coefficients per polynomial.
- REJ_Q, 8380417, modulus.
- COEFF_W, 23, coefficient width; must be >= clog2(REJ_Q).

Ports:
- clk, input, 1, clock.
- rst_b, input, 1, synchronous active-low reset.
- zeroize, input, 1, synchronous clear; identical effect to reset.
- start, input, 1, one-cycle pulse that begins a polynomial. Ignored unless the block is IDLE.
- eta_mode, input, 1, sampled on start: 0 selects eta=2, 1 selects eta=4.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block accepts in_data this cycle.
- in_data, input, 4*NUM_NIBBLES, candidates; nibble 0 is [3:0] and is processed first.
- out_valid, output, 1, a coefficient beat is available.
- out_ready, input, 1, downstream accepts the beat.
- out_data, output, NUM_COEFF_OUT*COEFF_W, coefficients; lane 0 is in the LSBs and is the oldest.
- done, output, 1, one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset/zeroize values: state=IDLE; buffer count=0; coefficient counter=0; eta latch=0; all outputs 0, including out_data. zeroize has priority over every other input.
- States and transitions:
  - IDLE to RUN on start, latching eta_mode.
  - RUN to DONE in the cycle the output beat that brings the counter to NUM_COEFF is accepted.
  - DONE to IDLE after one cycle; done=1 only while in DONE.
  - Reset or zeroize mid-operation returns to IDLE immediately, with all buffered data discarded.
- Acceptance rule for a nibble t:
  - eta=2: t<15. Remainder r = t mod 5, computed as the 4-bit fold (t[1:0]-t[3:2]) with +5 correction. Coefficient = (2-r) mod REJ_Q.
  - eta=4: t<9. Coefficient = (4-t) mod REJ_Q.
  - Negative results wrap to REJ_Q-k; for example, eta=2 with r=3 gives REJ_Q-1.
- Input handshake:
  - in_ready = (state==RUN) & (BUF_DEPTH-count >= NUM_NIBBLES), computed from registered count only.
  - Transfer occurs when in_valid&in_ready.
  - Accepted coefficients append after existing buffer entries in nibble order; rejected nibbles leave no gap.
  - The buffer updates on the clock edge after the transfer.
- Output handshake:
  - out_valid = (state==RUN) & (count >= NUM_COEFF_OUT).
  - out_data is driven directly from buffer entries 0..NUM_COEFF_OUT-1, so a coefficient accepted at cycle N can appear at N+1.
  - out_data and out_valid hold stable while out_valid & !out_ready.
  - Transfer occurs when out_valid&out_ready: the buffer shifts down by NUM_COEFF_OUT and the counter advances by NUM_COEFF_OUT.
- Simultaneous input and output transfer in one cycle: next count = count + accepted - NUM_COEFF_OUT. The new entries land directly after the surviving ones; no coefficient is lost or duplicated.
- Termination:
  - Once the final beat is accepted, in_ready and out_valid are 0.
  - Leftover buffered coefficients are discarded and count clears on entering DONE.
  - Input words arriving in DONE or IDLE are not accepted.
- NUM_COEFF must be a multiple of NUM_COEFF_OUT. The counter width is clog2(NUM_COEFF+1) and it never wraps.
- A word with zero accepted nibbles is still consumed when in_ready=1.

Test Plan:
- Reset: hold rst_b=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, done=0, out_data=0. zeroize asserted mid-RUN with count=5 -> next cycle is IDLE with count=0.
- eta=2, in_data=0x00000E53, out_ready=1 -> all 8 nibbles accepted. Next cycle out_data lanes 0..3 = {8380416, 2, 8380415, 2}, then {2, 2, 2, 2}.
- eta=2, in_data=0xFFFFFFFF -> nothing accepted, in_ready stays 1, out_valid stays 0. eta=4, in_data=0xFFFFFF95 -> one coefficient 8380416 buffered, out_valid=0.
- Backpressure: eta=4, in_data=0x33333333 continuously, out_ready=0 -> count reaches 16 and in_ready drops. out_data holds {1, 1, 1, 1}. After releasing out_ready, no coefficient is lost.
- Full polynomial: eta=2, random stream with ~10% nibbles=0xF and random out_ready -> exactly 64 beats. done pulses once, 1 cycle after the 64th accepted beat, and coefficients match the golden model in order.
- start pulsed during RUN -> ignored, and the eta latch is unchanged. start in IDLE with eta_mode=1 followed by 0x00000008 -> coefficient 8380413 (REJ_Q-4).
